// File: rtl/csi2_yuv422_unpacker_pkg.sv
// Shared datatype codes, pair-FIFO entry layout and FSM state types for the YUV422 unpacker.
package csi2_yuv422_unpacker_pkg;

  localparam logic [5:0] DT_YUV422_8 = 6'h1E;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;

  // Pair entry layout: {Y0, U, Y1, V, sol, eol}
  localparam int ENTRY_W = 34;
  localparam int F_EOL   = 0;
  localparam int F_SOL   = 1;
  localparam int F_V     = 2;
  localparam int F_Y1    = 10;
  localparam int F_U     = 18;
  localparam int F_Y0    = 26;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_ACCEPT,
    IN_DROP
  } inState_t;

  typedef enum logic {
    PIX0,
    PIX1
  } pixState_t;

endpackage

// File: rtl/csi2_pair_fifo.sv
// Synchronous FIFO holding unpacked U/Y0/V/Y1 pairs; reports free entries for decoder throttling.
module csi2_pair_fifo #(
  parameter int pWidth = 34,
  parameter int pDepth = 16
) (
  input  logic                     iClk,
  input  logic                     inRst,
  input  logic                     iPush,
  input  logic [pWidth-1:0]        iData,
  input  logic                     iPop,
  output logic [pWidth-1:0]        oData,
  output logic                     oEmpty,
  output logic                     oFull,
  output logic [$clog2(pDepth):0]  oFree
);

  localparam int AW = $clog2(pDepth);
  localparam logic [AW:0] DepthC = (AW+1)'(pDepth);

  logic [pWidth-1:0] rMem [pDepth];
  logic [AW:0]       rWrPtr;
  logic [AW:0]       rRdPtr;
  logic [AW:0]       wCount;
  logic              wWr;
  logic              wRd;

  assign wCount = rWrPtr - rRdPtr;
  assign oEmpty = (wCount == '0);
  assign oFull  = (wCount == DepthC);
  assign oFree  = DepthC - wCount;
  assign oData  = rMem[rRdPtr[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a push while full is accepted alongside it.
  assign wWr = iPush && (!oFull || iPop);
  assign wRd = iPop && !oEmpty;

  always_ff @(posedge iClk or negedge inRst) begin
    if (!inRst) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
    end else begin
      if (wWr) rWrPtr <= rWrPtr + 1'b1;
      if (wRd) rRdPtr <= rRdPtr + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (wWr) rMem[rWrPtr[AW-1:0]] <= iData;
  end

endmodule

// File: rtl/csi2_yuv422_unpacker.sv
// Unpacks CSI-2 YUV422 8-bit payload words into one Y/Cb/Cr pixel per clock with line/frame markers.
// Optional statistics outputs are enabled by defining CSI2_UNPACK_STAT_EN.
module csi2_yuv422_unpacker
  import csi2_yuv422_unpacker_pkg::*;
#(
  parameter int pVideoHeight = 1080,
  parameter int pFifoDepth   = 16,
  parameter int pFullAlMost  = 4
) (
  input  logic        iSCLK,
  input  logic        inSRST,
  input  logic [31:0] iHsPixel,
  input  logic [5:0]  iHsDatatype,
  input  logic [15:0] iHsWordCnt,
  input  logic        iHsValid,
  output logic        oEdv,
  output logic [7:0]  oY,
  output logic [7:0]  oCb,
  output logic [7:0]  oCr,
  output logic        oVd,
  output logic        oSol,
  output logic        oEol,
  output logic        oSof,
  output logic        oEof,
`ifdef CSI2_UNPACK_STAT_EN
  output logic [15:0] oStLineCnt,
  output logic [15:0] oStDropCnt,
  output logic        oStWcErr,
  output logic        oStOvf,
`endif
  input  logic        iRdy
);

  localparam int CW = $clog2(pFifoDepth) + 1;
  localparam logic [15:0]   LastLine    = 16'(pVideoHeight - 1);
  localparam logic [CW-1:0] FullAlMostC = CW'(pFullAlMost);

  inState_t           rInState;
  inState_t           wInNext;
  pixState_t          rPixState;
  pixState_t          wPixNext;
  logic [16:0]        rByteCnt;
  logic [16:0]        wCntNext;
  logic [16:0]        wWcExt;
  logic [7:0]         rU;
  logic [7:0]         rY0;
  logic               wDtOk;
  logic               wLast;
  logic               wLineStart;
  logic               wLatchEven;
  logic               wPush;
  logic               wSol;
  logic               wEol;
  logic [ENTRY_W-1:0] wEntry;
  logic [ENTRY_W-1:0] wHead;
  logic [ENTRY_W-1:0] rPair;
  logic               rPairVld;
  logic               wEmpty;
  logic               wFull;
  logic               wPop;
  logic               wXfer;
  logic [CW-1:0]      wFree;
  logic               rEdv;
  logic               rOvf;
  logic [15:0]        rLine;
  logic               wunusedBits;

  assign wDtOk      = (iHsDatatype == DT_YUV422_8);
  assign wWcExt     = {1'b0, iHsWordCnt};
  assign wCntNext   = (rInState == IN_IDLE) ? 17'd2 : rByteCnt + 17'd2;
  assign wLast      = (wCntNext >= wWcExt);
  assign wLineStart = iHsValid && (rInState == IN_IDLE);

  // The line's first word is always an even word; later words alternate on byte-counter bit 1.
  assign wLatchEven = iHsValid && ((wLineStart && wDtOk) ||
                                   ((rInState == IN_ACCEPT) && !rByteCnt[1]));
  assign wPush      = iHsValid && (rInState == IN_ACCEPT) && rByteCnt[1] && (wCntNext <= wWcExt);
  assign wSol       = (rByteCnt == 17'd2);
  assign wEol       = ((wCntNext + 17'd4) > wWcExt);
  assign wEntry     = {rY0, rU, iHsPixel[15:8], iHsPixel[7:0], wSol, wEol};

  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) rInState <= IN_IDLE;
    else         rInState <= wInNext;
  end

  always_comb begin
    wInNext = rInState;
    if (wLineStart) begin
      if (!wLast) wInNext = wDtOk ? IN_ACCEPT : IN_DROP;
    end else if (iHsValid && wLast) begin
      wInNext = IN_IDLE;
    end
  end

  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) begin
      rByteCnt <= '0;
      rU       <= '0;
      rY0      <= '0;
    end else begin
      if (iHsValid) rByteCnt <= wCntNext;
      if (wLatchEven) begin
        rU  <= iHsPixel[7:0];
        rY0 <= iHsPixel[15:8];
      end
    end
  end

  csi2_pair_fifo #(
    .pWidth (ENTRY_W),
    .pDepth (pFifoDepth)
  ) uPairFifo (
    .iClk   (iSCLK),
    .inRst  (inSRST),
    .iPush  (wPush),
    .iData  (wEntry),
    .iPop   (wPop),
    .oData  (wHead),
    .oEmpty (wEmpty),
    .oFull  (wFull),
    .oFree  (wFree)
  );

  // rPair is the pair being emitted; it refills when empty or as PIX1 transfers.
  assign wXfer = rPairVld && iRdy;
  assign wPop  = !wEmpty && (!rPairVld || (wXfer && (rPixState == PIX1)));

  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) rPixState <= PIX0;
    else         rPixState <= wPixNext;
  end

  always_comb begin
    wPixNext = rPixState;
    if (wXfer) wPixNext = (rPixState == PIX0) ? PIX1 : PIX0;
  end

  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) begin
      rPair    <= '0;
      rPairVld <= 1'b0;
    end else if (wPop) begin
      rPair    <= wHead;
      rPairVld <= 1'b1;
    end else if (wXfer && (rPixState == PIX1)) begin
      rPairVld <= 1'b0;
    end
  end

  assign oVd  = rPairVld;
  assign oY   = (rPixState == PIX0) ? rPair[F_Y0 +: 8] : rPair[F_Y1 +: 8];
  assign oCb  = rPair[F_U +: 8];
  assign oCr  = rPair[F_V +: 8];
  assign oSol = rPairVld && (rPixState == PIX0) && rPair[F_SOL];
  assign oEol = rPairVld && (rPixState == PIX1) && rPair[F_EOL];
  assign oSof = oSol && (rLine == '0);
  assign oEof = oEol && (rLine == LastLine);
  assign oEdv = rEdv;

  // The threshold leaves room for the words the decoder still sends after oEdv falls.
  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) begin
      rLine <= '0;
      rEdv  <= 1'b1;
      rOvf  <= 1'b0;
    end else begin
      rEdv <= (wFree > FullAlMostC);
      if (wXfer && oEol) rLine <= (rLine == LastLine) ? '0 : rLine + 16'd1;
      if (wPush && wFull && !wPop) rOvf <= 1'b1;
    end
  end

`ifdef CSI2_UNPACK_STAT_EN
  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) begin
      oStLineCnt <= '0;
      oStDropCnt <= '0;
      oStWcErr   <= 1'b0;
    end else if (wLineStart) begin
      if (wDtOk) oStLineCnt <= oStLineCnt + 16'd1;
      if (!wDtOk && (oStDropCnt != 16'hFFFF)) oStDropCnt <= oStDropCnt + 16'd1;
      if (wDtOk && (iHsWordCnt[1:0] != 2'b00)) oStWcErr <= 1'b1;
    end
  end

  assign oStOvf      = rOvf;
  assign wunusedBits = ^iHsPixel[31:16];
`else
  assign wunusedBits = ^{iHsPixel[31:16], rOvf};
`endif

endmodule

// File: tb/tb_csi2_yuv422_unpacker.sv
// Scoreboard bench for csi2_yuv422_unpacker: directed lines, monitor compares every transferred pixel.
module tb_csi2_yuv422_unpacker;

  localparam int H = 2;
  localparam int EDV_BUDGET = 500;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       sol;
    logic       eol;
    logic       sof;
    logic       eof;
  } pix_t;

  logic        clk = 1'b0;
  logic        inSRST;
  logic [31:0] iHsPixel;
  logic [5:0]  iHsDatatype;
  logic [15:0] iHsWordCnt;
  logic        iHsValid;
  logic        oEdv;
  logic [7:0]  oY;
  logic [7:0]  oCb;
  logic [7:0]  oCr;
  logic        oVd;
  logic        oSol;
  logic        oEol;
  logic        oSof;
  logic        oEof;
  logic        iRdy;
`ifdef CSI2_UNPACK_STAT_EN
  logic [15:0] oStLineCnt;
  logic [15:0] oStDropCnt;
  logic        oStWcErr;
  logic        oStOvf;
`endif

  int          checks = 0;
  int          fails = 0;
  int          modelLine = 0;
  logic        sawEdvLow = 1'b0;
  pix_t        expQ[$];
  logic [15:0] wordQ[$];
  pix_t        monAct;
  pix_t        monExp;

  csi2_yuv422_unpacker #(
    .pVideoHeight (H),
    .pFifoDepth   (16),
    .pFullAlMost  (4)
  ) dut (
    .iSCLK       (clk),
    .inSRST      (inSRST),
    .iHsPixel    (iHsPixel),
    .iHsDatatype (iHsDatatype),
    .iHsWordCnt  (iHsWordCnt),
    .iHsValid    (iHsValid),
    .oEdv        (oEdv),
    .oY          (oY),
    .oCb         (oCb),
    .oCr         (oCr),
    .oVd         (oVd),
    .oSol        (oSol),
    .oEol        (oEol),
    .oSof        (oSof),
    .oEof        (oEof),
`ifdef CSI2_UNPACK_STAT_EN
    .oStLineCnt  (oStLineCnt),
    .oStDropCnt  (oStDropCnt),
    .oStWcErr    (oStWcErr),
    .oStOvf      (oStOvf),
`endif
    .iRdy        (iRdy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Expected pixel; frame markers follow the bench's own line counter.
  task automatic expPix(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input logic sol, input logic eol);
    pix_t p;
    p.y   = y;
    p.cb  = cb;
    p.cr  = cr;
    p.sol = sol;
    p.eol = eol;
    p.sof = sol && (modelLine == 0);
    p.eof = eol && (modelLine == H - 1);
    expQ.push_back(p);
    if (eol) modelLine = (modelLine == H - 1) ? 0 : modelLine + 1;
  endtask

  task automatic expFromWords(input int wc);
    int pairs;
    logic [15:0] w0;
    logic [15:0] w1;
    pairs = wc / 4;
    for (int p = 0; p < pairs; p++) begin
      w0 = wordQ[2*p];
      w1 = wordQ[2*p+1];
      expPix(w0[15:8], w0[7:0], w1[7:0], p == 0, 1'b0);
      expPix(w1[15:8], w0[7:0], w1[7:0], 1'b0, p == pairs - 1);
    end
  endtask

  // Decoder model: presents the next word only while oEdv is high.
  task automatic applyStimulus(input logic [15:0] w);
    int waitCnt;
    waitCnt = 0;
    @(posedge clk); #1;
    while (!oEdv && waitCnt < EDV_BUDGET) begin
      iHsValid = 1'b0;
      waitCnt++;
      @(posedge clk); #1;
    end
    if (!oEdv) begin
      checks++;
      fails++;
      $display("[TB] FAIL edv_timeout got oEdv=0 expected oEdv=1 within %0d cycles", EDV_BUDGET);
    end
    iHsPixel = {16'hDEAD, w};
    iHsValid = 1'b1;
  endtask

  task automatic sendLine(input logic [5:0] dt, input int wc);
    iHsDatatype = dt;
    iHsWordCnt  = 16'(wc);
    for (int i = 0; i < (wc + 1) / 2; i++) applyStimulus(wordQ[i]);
    @(posedge clk); #1;
    iHsValid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    checkOutput("drain", expQ.size(), 0);
  endtask

  task automatic resetDut();
    @(posedge clk); #1;
    inSRST = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_edv", oEdv, 1);
    checkOutput("reset_vd", oVd, 0);
    inSRST = 1'b1;
    modelLine = 0;
  endtask

  initial begin
    inSRST      = 1'b0;
    iHsPixel    = '0;
    iHsDatatype = '0;
    iHsWordCnt  = '0;
    iHsValid    = 1'b0;
    iRdy        = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (inSRST && oVd && iRdy) begin
          monAct = {oY, oCb, oCr, oSol, oEol, oSof, oEof};
          checks++;
          if (expQ.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_pixel got %h expected no pixel", monAct);
          end else begin
            monExp = expQ.pop_front();
            if (monAct !== monExp) begin
              fails++;
              $display("[TB] FAIL pixel got y/cb/cr/sol/eol/sof/eof=%h expected %h", monAct, monExp);
            end
          end
        end
      end
      forever begin
        @(negedge clk);
        if (inSRST && !oEdv) sawEdvLow = 1'b1;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_edv", oEdv, 1);
        checkOutput("rst_vd", oVd, 0);
        checkOutput("rst_pix", {oY, oCb, oCr}, 0);
        checkOutput("rst_flags", {oSol, oEol, oSof, oEof}, 0);
        inSRST = 1'b1;

        $display("[TB] test 1: basic YUV422 line");
        wordQ = '{16'h1080, 16'h2090, 16'h30A0, 16'h40B0};
        expPix(8'h10, 8'h80, 8'h90, 1'b1, 1'b0);
        expPix(8'h20, 8'h80, 8'h90, 1'b0, 1'b0);
        expPix(8'h30, 8'hA0, 8'hB0, 1'b0, 1'b0);
        expPix(8'h40, 8'hA0, 8'hB0, 1'b0, 1'b1);
        sendLine(6'h1E, 8);
        waitDrain(200);

        $display("[TB] test 2: RAW8 line dropped, next YUV line unpacks");
        wordQ = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        sendLine(6'h2A, 8);
        wordQ = '{16'h11AA, 16'h22BB, 16'h33CC, 16'h44DD};
        expPix(8'h11, 8'hAA, 8'hBB, 1'b1, 1'b0);
        expPix(8'h22, 8'hAA, 8'hBB, 1'b0, 1'b0);
        expPix(8'h33, 8'hCC, 8'hDD, 1'b0, 1'b0);
        expPix(8'h44, 8'hCC, 8'hDD, 1'b0, 1'b1);
        sendLine(6'h1E, 8);
        waitDrain(200);
        checkOutput("edv_stays_high", sawEdvLow, 0);
`ifdef CSI2_UNPACK_STAT_EN
        checkOutput("stat_drop_cnt", oStDropCnt, 1);
`endif

        $display("[TB] test 3: downstream stall during a 1920-pixel line");
        wordQ.delete();
        for (int k = 0; k < 1920; k++) wordQ.push_back({8'(k), 8'(k ^ 90)});
        expFromWords(3840);
        fork
          sendLine(6'h1E, 3840);
          begin
            repeat (300) @(posedge clk);
            #1 iRdy = 1'b0;
            repeat (40) @(posedge clk);
            #1 iRdy = 1'b1;
          end
        join
        waitDrain(4000);
        checkOutput("edv_fell", sawEdvLow, 1);
`ifdef CSI2_UNPACK_STAT_EN
        checkOutput("stat_ovf", oStOvf, 0);
`endif

        $display("[TB] test 4: frame markers across three lines");
        resetDut();
        for (int l = 0; l < 3; l++) begin
          wordQ.delete();
          for (int k = 0; k < 4; k++) wordQ.push_back({8'(16*l + k + 1), 8'(8'hC0 + 4*l + k)});
          expFromWords(8);
          sendLine(6'h1E, 8);
        end
        waitDrain(200);

        $display("[TB] test 5: word count not a multiple of 4");
        wordQ = '{16'h1155, 16'h2266, 16'h3377};
        expPix(8'h11, 8'h55, 8'h66, 1'b1, 1'b0);
        expPix(8'h22, 8'h55, 8'h66, 1'b0, 1'b1);
        sendLine(6'h1E, 6);
        waitDrain(200);
`ifdef CSI2_UNPACK_STAT_EN
        checkOutput("stat_wc_err", oStWcErr, 1);
`endif

        $display("[TB] test 6: reset in the middle of a line");
        @(posedge clk); #1;
        iRdy = 1'b0;
        iHsDatatype = 6'h1E;
        iHsWordCnt  = 16'd8;
        applyStimulus(16'h5A01);
        applyStimulus(16'h6B02);
        applyStimulus(16'h7C03);
        @(posedge clk); #1;
        iHsValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pre_reset_vd", oVd, 1);
        checkOutput("pre_reset_y", oY, 8'h5A);
        inSRST = 1'b0;
        #1;
        checkOutput("mid_reset_vd", oVd, 0);
        checkOutput("mid_reset_pix", {oY, oCb, oCr}, 0);
        checkOutput("mid_reset_edv", oEdv, 1);
        @(posedge clk); #1;
        inSRST = 1'b1;
        iRdy = 1'b1;
        modelLine = 0;
        wordQ = '{16'h1A2B, 16'h3C4D, 16'h5E6F, 16'h7081};
        expPix(8'h1A, 8'h2B, 8'h4D, 1'b1, 1'b0);
        expPix(8'h3C, 8'h2B, 8'h4D, 1'b0, 1'b0);
        expPix(8'h5E, 8'h6F, 8'h81, 1'b0, 1'b0);
        expPix(8'h70, 8'h6F, 8'h81, 1'b0, 1'b1);
        sendLine(6'h1E, 8);
        waitDrain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
    join_any
  end

endmodule
